// File: rtl/servile_sram_wb_bridge.sv
// Byte-wide SRAM-style client port to a 32-bit Wishbone initiator.
// A one-word read buffer serves sequential byte reads; writes pass through as single-byte cycles.
module servile_sram_wb_bridge #(
    parameter int aw = 8
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic [aw-1:0] i_waddr,
    input  logic [7:0]    i_wdata,
    input  logic          i_wen,
    input  logic [aw-1:0] i_raddr,
    input  logic          i_ren,
    output logic [7:0]    o_rdata,
    output logic          o_rvalid,
    output logic          o_busy,
    output logic [aw-3:0] o_wb_adr,
    output logic [31:0]   o_wb_dat,
    output logic [3:0]    o_wb_sel,
    output logic          o_wb_we,
    output logic          o_wb_stb,
    input  logic [31:0]   i_wb_rdt,
    input  logic          i_wb_ack
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_READ  = 2'd2
    } state_t;

    state_t          state_r;
    logic [aw-1:0]   waddr_r;
    logic [7:0]      wdata_r;
    logic [aw-1:0]   raddr_r;
    logic            ren_r;
    logic [31:0]     buf_dat_r;
    logic [aw-3:0]   buf_adr_r;
    logic            buf_vld_r;

    logic            wtag_hit_s;
    logic            rd_hit_upd_s;
    logic            in_hit_s;
    logic [31:0]     buf_upd_s;

    function automatic logic [7:0] get_byte(input logic [31:0] w, input logic [1:0] idx);
        case (idx)
            2'd0:    get_byte = w[7:0];
            2'd1:    get_byte = w[15:8];
            2'd2:    get_byte = w[23:16];
            default: get_byte = w[31:24];
        endcase
    endfunction

    function automatic logic [31:0] set_byte(input logic [31:0] w, input logic [1:0] idx,
                                             input logic [7:0] b);
        logic [31:0] r;
        r = w;
        case (idx)
            2'd0:    r[7:0]   = b;
            2'd1:    r[15:8]  = b;
            2'd2:    r[23:16] = b;
            default: r[31:24] = b;
        endcase
        set_byte = r;
    endfunction

    // Buffer tag compares and the buffer contents as they will be after the pending write
    always_comb begin
        wtag_hit_s   = buf_vld_r && (buf_adr_r == waddr_r[aw-1:2]);
        rd_hit_upd_s = buf_vld_r && (buf_adr_r == raddr_r[aw-1:2]);
        in_hit_s     = buf_vld_r && (buf_adr_r == i_raddr[aw-1:2]);
        buf_upd_s    = wtag_hit_s ? set_byte(buf_dat_r, waddr_r[1:0], wdata_r) : buf_dat_r;
    end

    // Request FSM with registered client and Wishbone outputs
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_r   <= ST_IDLE;
            waddr_r   <= '0;
            wdata_r   <= 8'h00;
            raddr_r   <= '0;
            ren_r     <= 1'b0;
            buf_dat_r <= 32'h0000_0000;
            buf_adr_r <= '0;
            buf_vld_r <= 1'b0;
            o_rdata   <= 8'h00;
            o_rvalid  <= 1'b0;
            o_busy    <= 1'b0;
            o_wb_adr  <= '0;
            o_wb_dat  <= 32'h0000_0000;
            o_wb_sel  <= 4'h0;
            o_wb_we   <= 1'b0;
            o_wb_stb  <= 1'b0;
        end else begin
            o_rvalid <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (i_wen || i_ren) begin
                        waddr_r <= i_waddr;
                        wdata_r <= i_wdata;
                        raddr_r <= i_raddr;
                        ren_r   <= i_ren;
                        if (i_wen) begin
                            state_r  <= ST_WRITE;
                            o_busy   <= 1'b1;
                            o_wb_stb <= 1'b1;
                            o_wb_we  <= 1'b1;
                            o_wb_adr <= i_waddr[aw-1:2];
                            o_wb_dat <= {4{i_wdata}};
                            o_wb_sel <= 4'b0001 << i_waddr[1:0];
                        end else if (in_hit_s) begin
                            o_rdata  <= get_byte(buf_dat_r, i_raddr[1:0]);
                            o_rvalid <= 1'b1;
                        end else begin
                            state_r  <= ST_READ;
                            o_busy   <= 1'b1;
                            o_wb_stb <= 1'b1;
                            o_wb_we  <= 1'b0;
                            o_wb_adr <= i_raddr[aw-1:2];
                            o_wb_dat <= 32'h0000_0000;
                            o_wb_sel <= 4'hF;
                        end
                    end
                end
                ST_WRITE: begin
                    if (i_wb_ack) begin
                        buf_dat_r <= buf_upd_s;
                        // A read that misses chains straight into a read cycle, strobe kept high
                        if (ren_r && !rd_hit_upd_s) begin
                            state_r  <= ST_READ;
                            o_wb_we  <= 1'b0;
                            o_wb_adr <= raddr_r[aw-1:2];
                            o_wb_dat <= 32'h0000_0000;
                            o_wb_sel <= 4'hF;
                        end else begin
                            state_r  <= ST_IDLE;
                            o_busy   <= 1'b0;
                            o_wb_stb <= 1'b0;
                            o_wb_we  <= 1'b0;
                            o_wb_dat <= 32'h0000_0000;
                            o_wb_sel <= 4'h0;
                            if (ren_r) begin
                                o_rdata  <= get_byte(buf_upd_s, raddr_r[1:0]);
                                o_rvalid <= 1'b1;
                            end
                        end
                    end
                end
                ST_READ: begin
                    if (i_wb_ack) begin
                        buf_dat_r <= i_wb_rdt;
                        buf_adr_r <= raddr_r[aw-1:2];
                        buf_vld_r <= 1'b1;
                        o_rdata   <= get_byte(i_wb_rdt, raddr_r[1:0]);
                        o_rvalid  <= 1'b1;
                        state_r   <= ST_IDLE;
                        o_busy    <= 1'b0;
                        o_wb_stb  <= 1'b0;
                        o_wb_sel  <= 4'h0;
                    end
                end
                default: begin
                    state_r  <= ST_IDLE;
                    o_busy   <= 1'b0;
                    o_wb_stb <= 1'b0;
                    o_wb_we  <= 1'b0;
                    o_wb_dat <= 32'h0000_0000;
                    o_wb_sel <= 4'h0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_servile_sram_wb_bridge.sv
// Self-checking bench for servile_sram_wb_bridge: Wishbone slave model with wait states,
// a byte-level reference memory and a read-data scoreboard.
module tb_servile_sram_wb_bridge;

    logic        clk = 1'b0;
    logic        rst, wen, ren;
    logic [7:0]  waddr, wdata, raddr;
    logic [7:0]  rdata;
    logic        rvalid, busy;
    logic [5:0]  wb_adr;
    logic [31:0] wb_dat;
    logic [3:0]  wb_sel;
    logic        wb_we, wb_stb;
    logic [31:0] wb_rdt = 32'h0;
    logic        wb_ack = 1'b0;

    typedef struct packed {
        logic        we;
        logic [5:0]  adr;
        logic [3:0]  sel;
        logic [31:0] dat;
    } wb_t;

    wb_t         wb_log[$];
    logic [7:0]  sb_q[$];
    logic [7:0]  sb_exp;
    logic [7:0]  ref_mem [256];
    logic [31:0] slv_mem [64];
    bit          slv_init = 1'b0;
    int          slv_mode = 0;
    int          slv_waits = 2;
    int          slv_cnt = 0;
    int          stb_cycles = 0;
    int          n_cmp = 0;
    int          n_err = 0;
    int          n0, s0, gaps;

    always #5 clk = ~clk;

    servile_sram_wb_bridge #(.aw(8)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_waddr(waddr), .i_wdata(wdata), .i_wen(wen),
        .i_raddr(raddr), .i_ren(ren),
        .o_rdata(rdata), .o_rvalid(rvalid), .o_busy(busy),
        .o_wb_adr(wb_adr), .o_wb_dat(wb_dat), .o_wb_sel(wb_sel),
        .o_wb_we(wb_we), .o_wb_stb(wb_stb),
        .i_wb_rdt(wb_rdt), .i_wb_ack(wb_ack)
    );

    function automatic logic [7:0] init_byte(input int a);
        int v;
        v = (a % 4 + 1) * 17 + a / 4 - 4;
        return 8'(v);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    // Slave model: ack after slv_waits wait states; mode 1 never acks, mode 2 acks unconditionally
    always @(negedge clk) begin
        if (rst) begin
            wb_ack  = 1'b0;
            slv_cnt = 0;
            if (!slv_init) begin
                for (int w = 0; w < 64; w++)
                    slv_mem[w] = {init_byte(w*4+3), init_byte(w*4+2), init_byte(w*4+1), init_byte(w*4)};
                slv_init = 1'b1;
            end
        end else if (slv_mode == 2) begin
            wb_ack = 1'b1;
        end else if (slv_mode == 1 || wb_ack) begin
            wb_ack  = 1'b0;
            slv_cnt = 0;
        end else if (wb_stb) begin
            if (slv_cnt >= slv_waits) begin
                wb_ack  = 1'b1;
                slv_cnt = 0;
                wb_rdt  = slv_mem[wb_adr];
                if (wb_we)
                    for (int b = 0; b < 4; b++)
                        if (wb_sel[b]) slv_mem[wb_adr][b*8 +: 8] = wb_dat[b*8 +: 8];
            end else begin
                slv_cnt++;
            end
        end
    end

    // Bus monitor: strobe cycles and every completed Wishbone cycle
    always @(posedge clk) begin
        if (wb_stb) stb_cycles++;
        if (wb_stb && wb_ack) wb_log.push_back({wb_we, wb_adr, wb_sel, wb_dat});
    end

    // Scoreboard: every read-data pulse must match the oldest expected byte
    always @(negedge clk) begin
        if (rvalid) begin
            if (sb_q.size() == 0) begin
                chk("rv_unexpected", rvalid, 0);
            end else begin
                sb_exp = sb_q.pop_front();
                chk("rdata", rdata, sb_exp);
            end
        end
    end

    task automatic req(input logic w, input logic [7:0] wa, input logic [7:0] wd,
                       input logic r, input logic [7:0] ra, input logic expect_rd);
        int n = 0;
        while (busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (busy) chk("req_timeout", busy, 0);
        wen = w; waddr = wa; wdata = wd;
        ren = r; raddr = ra;
        if (w) ref_mem[wa] = wd;
        if (r && expect_rd) sb_q.push_back(ref_mem[ra]);
        @(posedge clk);
        @(negedge clk);
        wen = 1'b0;
        ren = 1'b0;
    endtask

    task automatic wait_idle(output int g);
        int n = 0;
        g = 0;
        while (busy && n < 200) begin
            if (!wb_stb) g++;
            @(negedge clk);
            n++;
        end
        if (busy) chk("idle_timeout", busy, 0);
    endtask

    initial begin
        rst = 1'b1; wen = 1'b0; ren = 1'b0;
        waddr = 8'h00; wdata = 8'h00; raddr = 8'h00;
        for (int a = 0; a < 256; a++) ref_mem[a] = init_byte(a);
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_rvalid", rvalid, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_stb", wb_stb, 0);
        chk("rst_we", wb_we, 0);
        chk("rst_sel", wb_sel, 0);
        chk("rst_adr", wb_adr, 0);
        chk("rst_dat", wb_dat, 0);
        rst = 1'b0;
        @(negedge clk);

        // cold read of 0x11 with two wait states, then a hit on 0x12
        n0 = wb_log.size();
        req(1'b0, 8'h00, 8'h00, 1'b1, 8'h11, 1'b1);
        wait_idle(gaps);
        chk("cold_rvalid", rvalid, 1);
        chk("cold_rdata", rdata, 8'h22);
        chk("cold_ncyc", wb_log.size() - n0, 1);
        chk("cold_we", wb_log[wb_log.size()-1].we, 0);
        chk("cold_adr", wb_log[wb_log.size()-1].adr, 6'h04);
        chk("cold_sel", wb_log[wb_log.size()-1].sel, 4'hF);
        s0 = stb_cycles;
        req(1'b0, 8'h00, 8'h00, 1'b1, 8'h12, 1'b1);
        chk("hit_rvalid", rvalid, 1);
        chk("hit_rdata", rdata, 8'h33);
        chk("hit_busy", busy, 0);
        chk("hit_nostb", stb_cycles - s0, 0);

        // write hit updates the buffered word
        n0 = wb_log.size();
        req(1'b1, 8'h13, 8'hAA, 1'b0, 8'h00, 1'b0);
        wait_idle(gaps);
        chk("wr_rvalid", rvalid, 0);
        chk("wr_ncyc", wb_log.size() - n0, 1);
        chk("wr_we", wb_log[wb_log.size()-1].we, 1);
        chk("wr_adr", wb_log[wb_log.size()-1].adr, 6'h04);
        chk("wr_sel", wb_log[wb_log.size()-1].sel, 4'b1000);
        chk("wr_dat", wb_log[wb_log.size()-1].dat, 32'hAAAA_AAAA);
        s0 = stb_cycles;
        req(1'b0, 8'h00, 8'h00, 1'b1, 8'h13, 1'b1);
        chk("wrhit_rvalid", rvalid, 1);
        chk("wrhit_nostb", stb_cycles - s0, 0);

        // write miss does not allocate
        req(1'b1, 8'h20, 8'h5C, 1'b0, 8'h00, 1'b0);
        wait_idle(gaps);
        chk("wmiss_sel", wb_log[wb_log.size()-1].sel, 4'b0001);
        chk("wmiss_adr", wb_log[wb_log.size()-1].adr, 6'h08);
        n0 = wb_log.size();
        req(1'b0, 8'h00, 8'h00, 1'b1, 8'h20, 1'b1);
        wait_idle(gaps);
        chk("wmiss_rd_ncyc", wb_log.size() - n0, 1);
        chk("wmiss_rd_we", wb_log[wb_log.size()-1].we, 0);
        chk("wmiss_rd_rvalid", rvalid, 1);

        // reset in the middle of a read that the slave never acks
        slv_mode = 1;
        req(1'b0, 8'h00, 8'h00, 1'b1, 8'h40, 1'b0);
        @(negedge clk);
        chk("mid_stb", wb_stb, 1);
        chk("mid_busy", busy, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mrst_stb", wb_stb, 0);
        chk("mrst_busy", busy, 0);
        chk("mrst_rvalid", rvalid, 0);
        n0 = wb_log.size();
        s0 = stb_cycles;
        slv_mode = 2;
        @(negedge clk);
        slv_mode = 0;
        repeat (3) @(negedge clk);
        chk("stray_stb", stb_cycles - s0, 0);
        chk("stray_busy", busy, 0);
        chk("stray_rdata", rdata, 0);
        chk("stray_ncyc", wb_log.size() - n0, 0);

        // simultaneous write and read of byte 0x30 with an empty buffer
        slv_waits = 1;
        n0 = wb_log.size();
        req(1'b1, 8'h30, 8'h5C, 1'b1, 8'h30, 1'b1);
        wait_idle(gaps);
        chk("rw_gap", gaps, 0);
        chk("rw_ncyc", wb_log.size() - n0, 2);
        chk("rw_first_we", wb_log[n0].we, 1);
        chk("rw_first_sel", wb_log[n0].sel, 4'b0001);
        chk("rw_first_adr", wb_log[n0].adr, 6'h0C);
        chk("rw_second_we", wb_log[n0+1].we, 0);
        chk("rw_second_adr", wb_log[n0+1].adr, 6'h0C);
        chk("rw_rvalid", rvalid, 1);
        chk("rw_rdata", rdata, 8'h5C);

        // zero-wait slave: data at T+2 and a new request accepted at T+2
        slv_waits = 0;
        req(1'b0, 8'h00, 8'h00, 1'b1, 8'h50, 1'b1);
        chk("zw_stb", wb_stb, 1);
        chk("zw_busy1", busy, 1);
        @(negedge clk);
        chk("zw_rvalid", rvalid, 1);
        chk("zw_busy0", busy, 0);
        req(1'b0, 8'h00, 8'h00, 1'b1, 8'h51, 1'b1);
        chk("zw_next_rvalid", rvalid, 1);

        repeat (3) @(negedge clk);
        chk("sb_empty", sb_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
